// File: rtl/i2s_rx_dma_ctrl_if.sv
// Memory write-request port between the I2S receive sequencer and the bus master adapter.
interface i2s_rx_dma_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;

  modport master (output mem_valid, output mem_addr, output mem_wdata, input mem_ready);
  modport slave  (input mem_valid, input mem_addr, input mem_wdata, output mem_ready);
endinterface

// File: rtl/i2s_rx_dma_ctrl.sv
// Drains the I2S receive FIFO (first-word fall-through) into memory, one 32-bit word per write,
// with back-to-back pop/write for single-cycle throughput and a graceful abort path.
module i2s_rx_dma_ctrl #(
  parameter int AW     = 4,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [CNT_W-1:0]         xfer_count,
  input  logic                     fifo_empty,
  input  logic                     fifo_full,
  input  logic [31:0]              fifo_rdata,
  output logic                     fifo_rd,
  i2s_rx_dma_ctrl_if.master        mem,
  output logic                     busy,
  output logic                     done,
  output logic                     aborted,
  output logic                     overrun,
  output logic [CNT_W-1:0]         words_done
);

  // AW is carried only so the parameter list matches the I2S core it is paired with.
  if (AW < 1) begin : g_aw_invalid
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WRITE,
    S_FIN_DONE,
    S_FIN_ABORT
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [CNT_W-1:0]    remaining_q, remaining_d;
  logic [CNT_W-1:0]    words_done_q, words_done_d;
  logic                overrun_q, overrun_d;
  logic                abort_pend_q, abort_pend_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      remaining_q  <= '0;
      words_done_q <= '0;
      overrun_q    <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      remaining_q  <= remaining_d;
      words_done_q <= words_done_d;
      overrun_q    <= overrun_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    remaining_d  = remaining_q;
    words_done_d = words_done_q;
    overrun_d    = overrun_q;
    abort_pend_d = abort_pend_q;
    fifo_rd      = 1'b0;

    if ((state_q == S_FETCH || state_q == S_WRITE) && fifo_full) overrun_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        abort_pend_d = 1'b0;
        if (start) begin
          addr_d       = {base_addr[ADDR_W-1:2], 2'b00};
          remaining_d  = xfer_count;
          words_done_d = '0;
          overrun_d    = 1'b0;
          state_d      = (xfer_count == '0) ? S_FIN_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (abort) begin
          state_d = S_FIN_ABORT;
        end else if (!fifo_empty) begin
          wdata_d = fifo_rdata;
          fifo_rd = 1'b1;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (abort) abort_pend_d = 1'b1;
        if (mem.mem_ready) begin
          addr_d       = addr_q + ADDR_W'(4);
          remaining_d  = remaining_q - CNT_W'(1);
          words_done_d = words_done_q + CNT_W'(1);
          // Last beat completes as done even when an abort arrived during it.
          if (remaining_q == CNT_W'(1)) begin
            state_d = S_FIN_DONE;
          end else if (abort_pend_q || abort) begin
            state_d = S_FIN_ABORT;
          end else if (!fifo_empty) begin
            wdata_d = fifo_rdata;
            fifo_rd = 1'b1;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_FIN_DONE:  state_d = S_IDLE;
      S_FIN_ABORT: state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  assign mem.mem_valid = (state_q == S_WRITE);
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign busy          = (state_q == S_FETCH) || (state_q == S_WRITE);
  assign done          = (state_q == S_FIN_DONE);
  assign aborted       = (state_q == S_FIN_ABORT);
  assign overrun       = overrun_q;
  assign words_done    = words_done_q;

endmodule
